// File: rtl/mux_n_pipe.sv
// mux_n_pipe: parametrised N:1 datapath mux with a registered output stage,
// a one-entry skid buffer and valid/ready handshakes on both sides.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous clear of all buffered entries
//   in_valid   in_sel/in_data valid this cycle
//   in_ready   block accepts input this cycle (registered)
//   in_sel     channel select
//   in_data    flattened channels, channel i = in_data[i*WIDTH +: WIDTH]
//   out_valid  out_* hold a selected word (registered)
//   out_ready  consumer accepts out_* this cycle
//   out_data   selected word
//   out_sel    select value that produced out_data
//   out_err    in_sel was out of range; out_data is zero
module mux_n_pipe #(
    parameter  int unsigned WIDTH  = 32,
    parameter  int unsigned NUM_IN = 4,
    localparam int unsigned SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_err
);

    // Buffered payload layout: {err, sel, data}
    localparam int unsigned PAY_W = WIDTH + SEL_W + 1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PAY_W-1:0] r_main;
    logic [PAY_W-1:0] r_skid;
    logic [PAY_W-1:0] w_main_nxt;
    logic [PAY_W-1:0] w_skid_nxt;
    logic [PAY_W-1:0] w_word;
    logic [WIDTH-1:0] w_sel_data;
    logic             w_sel_err;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             w_accept;
    logic             w_pop;

    assign w_accept = in_valid & r_in_ready;
    assign w_pop    = r_out_valid & out_ready;

    // Channel selection; a select with no matching channel yields zero + err
    always_comb begin
        w_sel_data = '0;
        w_sel_err  = 1'b1;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (in_sel == SEL_W'(i)) begin
                w_sel_data = in_data[i*WIDTH +: WIDTH];
                w_sel_err  = 1'b0;
            end
        end
        w_word = {w_sel_err, in_sel, w_sel_data};
    end

    // Next-state and buffer update
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_main_nxt  = w_word;
                    w_state_nxt = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_accept && !w_pop) begin
                    w_skid_nxt  = w_word;
                    w_state_nxt = ST_FULL;
                end else if (w_accept && w_pop) begin
                    w_main_nxt  = w_word;
                end else if (w_pop) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_pop) begin
                    w_main_nxt  = r_skid;
                    w_state_nxt = ST_ONE;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
        // Flush drops everything buffered; payload registers keep last value
        if (flush) begin
            w_state_nxt = ST_EMPTY;
            w_main_nxt  = r_main;
            w_skid_nxt  = r_skid;
        end
    end

    // State, payload and handshake registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_main      <= '0;
            r_skid      <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_main      <= w_main_nxt;
            r_skid      <= w_skid_nxt;
            r_out_valid <= (w_state_nxt != ST_EMPTY);
            r_in_ready  <= (w_state_nxt != ST_FULL);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main[WIDTH-1:0];
    assign out_sel   = r_main[WIDTH +: SEL_W];
    assign out_err   = r_main[PAY_W-1];

endmodule

// File: tb/tb_mux_n_pipe.sv
// Bench for mux_n_pipe: directed tests on a 4x32 instance, out-of-range and
// random handshake traffic on a 5x8 instance, both scoreboard-checked.
module tb_mux_n_pipe;

    logic         clk;
    logic         rst_n;

    // Instance A: WIDTH=32, NUM_IN=4
    logic         a_flush, a_val, a_rdy, a_ord, a_ov, a_oe;
    logic [1:0]   a_sel, a_os;
    logic [127:0] a_data;
    logic [31:0]  a_od;

    // Instance B: WIDTH=8, NUM_IN=5
    logic         b_flush, b_val, b_rdy, b_ord, b_ov, b_oe;
    logic [2:0]   b_sel, b_os;
    logic [39:0]  b_data;
    logic [7:0]   b_od;

    int           n_vec = 0;
    int           n_err = 0;
    int           b_acc = 0;
    logic [63:0]  q_a[$];
    logic [63:0]  q_b[$];
    logic         b_stall = 1'b0;
    logic [11:0]  b_held  = '0;

    mux_n_pipe #(.WIDTH(32), .NUM_IN(4)) u_a (
        .clk(clk), .rst_n(rst_n), .flush(a_flush),
        .in_valid(a_val), .in_ready(a_rdy), .in_sel(a_sel), .in_data(a_data),
        .out_valid(a_ov), .out_ready(a_ord), .out_data(a_od),
        .out_sel(a_os), .out_err(a_oe)
    );

    mux_n_pipe #(.WIDTH(8), .NUM_IN(5)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(b_flush),
        .in_valid(b_val), .in_ready(b_rdy), .in_sel(b_sel), .in_data(b_data),
        .out_valid(b_ov), .out_ready(b_ord), .out_data(b_od),
        .out_sel(b_os), .out_err(b_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] exp_a(input logic [1:0] s, input logic [127:0] d);
        logic [31:0] w;
        w = d[32*s +: 32];
        return 64'({1'b0, s, w});
    endfunction

    function automatic logic [63:0] exp_b(input logic [2:0] s, input logic [39:0] d);
        logic [7:0] w;
        if (s < 3'd5) begin
            w = d[8*s +: 8];
            return 64'({1'b0, s, w});
        end
        return 64'({1'b1, s, 8'h00});
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard for A: pop on output transfer, push on input transfer
    always @(negedge clk) begin
        if (!rst_n || a_flush) begin
            q_a.delete();
        end else begin
            if (a_ov && a_ord) begin
                if (q_a.size() == 0) chk("a_unexpected_out", 64'(q_a.size()), 64'd1);
                else chk("a_out", 64'({a_oe, a_os, a_od}), q_a.pop_front());
            end
            if (a_val && a_rdy) q_a.push_back(exp_a(a_sel, a_data));
        end
    end

    // Scoreboard and stall-stability monitor for B
    always @(negedge clk) begin
        if (!rst_n) begin
            q_b.delete();
            b_stall = 1'b0;
        end else begin
            if (b_stall) chk("b_stable", 64'({b_ov, b_oe, b_os, b_od}), 64'({1'b1, b_held}));
            if (b_ov && b_ord) begin
                if (q_b.size() == 0) chk("b_unexpected_out", 64'(q_b.size()), 64'd1);
                else chk("b_out", 64'({b_oe, b_os, b_od}), q_b.pop_front());
            end
            if (b_val && b_rdy) begin
                q_b.push_back(exp_b(b_sel, b_data));
                b_acc++;
            end
            b_stall = b_ov & ~b_ord;
            b_held  = {b_oe, b_os, b_od};
        end
    end

    initial begin
        rst_n   = 1'b0;
        a_flush = 1'b0; a_val = 1'b0; a_ord = 1'b1; a_sel = '0;
        b_flush = 1'b0; b_val = 1'b0; b_ord = 1'b1; b_sel = '0; b_data = '0;
        for (int i = 0; i < 4; i++) a_data[32*i +: 32] = 32'h1111_1111 * 32'(i + 1);

        // Reset values
        repeat (2) step();
        chk("rst_a", 64'({a_ov, a_rdy, a_od, a_os, a_oe}), 64'({1'b0, 1'b1, 32'h0, 2'b00, 1'b0}));
        chk("rst_b", 64'({b_ov, b_rdy, b_od, b_os, b_oe}), 64'({1'b0, 1'b1, 8'h0, 3'b000, 1'b0}));
        #2 rst_n = 1'b1;
        step();

        // Select sweep at full throughput
        for (int i = 0; i < 4; i++) begin
            a_val = 1'b1;
            a_sel = 2'(i);
            step();
            chk("sweep_ov", 64'(a_ov), 64'd1);
            chk("sweep_rdy", 64'(a_rdy), 64'd1);
        end
        a_val = 1'b0;
        step();
        chk("sweep_done_ov", 64'(a_ov), 64'd0);

        // Back-pressure: A, B with consumer stalled
        a_ord = 1'b0;
        a_val = 1'b1; a_sel = 2'd0; step();
        chk("bp_rdy_one", 64'(a_rdy), 64'd1);
        a_sel = 2'd1; step();
        a_val = 1'b0;
        chk("bp_full_rdy", 64'(a_rdy), 64'd0);
        chk("bp_full_data", 64'(a_od), 64'h1111_1111);
        repeat (3) step();
        chk("bp_hold", 64'({a_ov, a_rdy, a_os, a_od}), 64'({1'b1, 1'b0, 2'd0, 32'h1111_1111}));
        a_ord = 1'b1; step();
        chk("bp_second", 64'({a_ov, a_rdy, a_os, a_od}), 64'({1'b1, 1'b1, 2'd1, 32'h2222_2222}));
        step();
        chk("bp_drained", 64'(a_ov), 64'd0);

        // Flush in FULL with a coincident input word
        a_ord = 1'b0;
        a_val = 1'b1; a_sel = 2'd2; step();
        a_sel = 2'd3; step();
        chk("fl_full_rdy", 64'(a_rdy), 64'd0);
        a_flush = 1'b1; a_sel = 2'd1; step();
        a_flush = 1'b0; a_val = 1'b0;
        chk("fl_after", 64'({a_ov, a_rdy}), 64'({1'b0, 1'b1}));
        a_ord = 1'b1;
        repeat (2) step();
        chk("fl_no_stale", 64'(a_ov), 64'd0);
        // Flush from EMPTY discards the coincident word
        a_flush = 1'b1; a_val = 1'b1; a_sel = 2'd2; step();
        a_flush = 1'b0; a_val = 1'b0;
        chk("fl_discard0", 64'(a_ov), 64'd0);
        step();
        chk("fl_discard1", 64'(a_ov), 64'd0);

        // Asynchronous reset mid-burst in FULL
        a_ord = 1'b0;
        a_val = 1'b1; a_sel = 2'd3; step();
        a_sel = 2'd2; step();
        chk("rb_full_rdy", 64'(a_rdy), 64'd0);
        #2 rst_n = 1'b0;
        #1 chk("rb_async", 64'({a_ov, a_rdy, a_od}), 64'({1'b0, 1'b1, 32'h0}));
        a_val = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        a_ord = 1'b1;
        repeat (3) step();
        chk("rb_no_stale", 64'({a_ov, a_rdy}), 64'({1'b0, 1'b1}));

        // Out-of-range select on the 5-input instance
        b_ord = 1'b1;
        b_data = {5{8'hEF}};
        b_val = 1'b1; b_sel = 3'd5; step();
        chk("oor_err", 64'({b_ov, b_oe, b_os, b_od}), 64'({1'b1, 1'b1, 3'd5, 8'h00}));
        b_sel = 3'd4; step();
        b_val = 1'b0;
        chk("oor_next", 64'({b_ov, b_oe, b_os, b_od}), 64'({1'b1, 1'b0, 3'd4, 8'hEF}));
        step();

        // Random valid/ready traffic
        b_acc = 0;
        for (int cyc = 0; cyc < 60000 && b_acc < 10000; cyc++) begin
            b_val  = ($urandom_range(0, 3) != 0);
            b_sel  = 3'($urandom_range(0, 7));
            b_data = {$urandom, 8'($urandom)};
            b_ord  = ($urandom_range(0, 3) != 0);
            step();
        end
        b_val = 1'b0;
        chk("rnd_accepted", 64'(b_acc), 64'd10000);
        b_ord = 1'b1;
        for (int i = 0; i < 50 && q_b.size() != 0; i++) step();
        step();
        chk("rnd_drained", 64'(q_b.size()), 64'd0);
        chk("rnd_idle", 64'(b_ov), 64'd0);
        chk("a_q_empty", 64'(q_a.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
